// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg : Gray decode helpers and shared limits for the Gray receive path
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gray_pkg;

   localparam int SYNC_MIN  = 2;
   localparam int GRAY_MAXW = 32;

   // Zero-extended inputs decode correctly: leading zeros leave the prefix XOR untouched.
   function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
      logic [GRAY_MAXW-1:0] b;
      b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
      for (int i = GRAY_MAXW-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic popcount_gt1(input logic [GRAY_MAXW-1:0] x);
      return (x & (x - GRAY_MAXW'(1))) != '0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain : plain multi-flop resynchroniser for a bus arriving from another clock
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_chain #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gray_binary_rx.sv
// ---------------------------------------------------------------------------
// gray_binary_rx : resynchronise a foreign Gray bus, decode to binary, flag illegal steps
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gray_binary_rx
   import gray_pkg::*;
#(
   parameter int SIZE        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SIZE-1:0]  gray_in,
   input  logic             clear_err,
   output logic [SIZE-1:0]  bin_out,
   output logic             bin_valid,
   output logic [SIZE-1:0]  bin_delta,
   output logic             step_err,
   output logic             sticky_err,
   output logic [ERR_W-1:0] err_count
);

   if (SYNC_STAGES < SYNC_MIN) begin : g_chk_sync
      $error("gray_binary_rx: SYNC_STAGES must be at least %0d", SYNC_MIN);
   end

   if (SIZE < 2 || SIZE > GRAY_MAXW) begin : g_chk_size
      $error("gray_binary_rx: SIZE must be in 2..%0d", GRAY_MAXW);
   end

   logic [SIZE-1:0]      g_s;
   logic [SIZE-1:0]      g_prev_q;
   logic [SIZE-1:0]      bin_q, bin_d;
   logic [SIZE-1:0]      delta_q, delta_d;
   logic                 valid_q;
   logic                 step_err_q, step_err_d;
   logic                 sticky_q, sticky_d;
   logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
   logic [GRAY_MAXW-1:0] g_ext, diff_ext, b_ext;
   logic                 changed;
   logic                 pad_unused;

   sync_chain #(
      .WIDTH  (SIZE),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (gray_in),
      .q     (g_s)
   );

   always_comb begin
      g_ext                = '0;
      g_ext[SIZE-1:0]      = g_s;
      diff_ext             = '0;
      diff_ext[SIZE-1:0]   = g_s ^ g_prev_q;
   end

   assign b_ext      = gray2bin(g_ext);
   assign pad_unused = ^b_ext;
   assign bin_d      = b_ext[SIZE-1:0];
   assign changed    = (g_s != g_prev_q);

   always_comb begin
      delta_d    = bin_d - bin_q;
      step_err_d = changed && popcount_gt1(diff_ext);
      err_cnt_d  = err_cnt_q;
      sticky_d   = sticky_q;
      // A clear on the same edge as an error wins; the error pulse itself still goes out.
      if (clear_err) begin
         err_cnt_d = '0;
         sticky_d  = 1'b0;
      end else if (step_err_d) begin
         sticky_d = 1'b1;
         if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_prev_q   <= '0;
         bin_q      <= '0;
         delta_q    <= '0;
         valid_q    <= 1'b0;
         step_err_q <= 1'b0;
         sticky_q   <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         valid_q    <= changed;
         step_err_q <= step_err_d;
         sticky_q   <= sticky_d;
         err_cnt_q  <= err_cnt_d;
         if (changed) begin
            g_prev_q <= g_s;
            bin_q    <= bin_d;
            delta_q  <= delta_d;
         end
      end
   end

   assign bin_out    = bin_q;
   assign bin_valid  = valid_q;
   assign bin_delta  = delta_q;
   assign step_err   = step_err_q;
   assign sticky_err = sticky_q;
   assign err_count  = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_binary_rx.sv
// ---------------------------------------------------------------------------
// tb_gray_binary_rx : scoreboard bench for gray_binary_rx against a value-level model
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_gray_binary_rx;

   localparam int SIZE        = 4;
   localparam int SYNC_STAGES = 2;
   localparam int ERR_W       = 2;
   localparam int MAXV        = 1 << SIZE;
   localparam int CNT_MAX     = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [SIZE-1:0]  gray_in = '0;
   logic             clear_err = 1'b0;
   logic [SIZE-1:0]  bin_out;
   logic             bin_valid;
   logic [SIZE-1:0]  bin_delta;
   logic             step_err;
   logic             sticky_err;
   logic [ERR_W-1:0] err_count;

   gray_binary_rx #(
      .SIZE        (SIZE),
      .SYNC_STAGES (SYNC_STAGES),
      .ERR_W       (ERR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .gray_in    (gray_in),
      .clear_err  (clear_err),
      .bin_out    (bin_out),
      .bin_valid  (bin_valid),
      .bin_delta  (bin_delta),
      .step_err   (step_err),
      .sticky_err (sticky_err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int bin;
      int delta;
      int err;
      int sticky;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_prev_g = 0, m_prev_b = 0, m_cnt = 0, m_sticky = 0;
   bit   clr_pipe0 = 1'b0, clr_pipe1 = 1'b0;
   int   cur_g = 0;

   function automatic int gray_of(input int n);
      return n ^ (n >> 1);
   endfunction

   // Binary value is whichever count encodes to the observed Gray word.
   function automatic int g2b(input int g);
      for (int v = 0; v < MAXV; v++) begin
         if (gray_of(v) == g) return v;
      end
      return -1;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_step(input int g, input bit clr);
      int b;
      int e;
      if (g != m_prev_g) begin
         b = g2b(g);
         e = ($countones(g ^ m_prev_g) > 1) ? 1 : 0;
         if (clr) begin
            m_cnt = 0; m_sticky = 0;
         end else if (e != 0) begin
            m_sticky = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
         end
         sb.push_back('{b, (b - m_prev_b + MAXV) % MAXV, e, m_sticky, m_cnt});
         m_prev_g = g;
         m_prev_b = b;
      end else if (clr) begin
         m_cnt = 0; m_sticky = 0;
      end
   endfunction

   // One stimulus cycle; a clear request is delayed so it meets the edge where this value's result lands.
   task automatic step(input int g, input bit clr);
      @(negedge clk);
      gray_in   = SIZE'(g);
      clear_err = clr_pipe1;
      clr_pipe1 = clr_pipe0;
      clr_pipe0 = clr;
      cur_g     = g;
      model_step(g, clr);
   endtask

   task automatic do_reset(input int g);
      @(negedge clk);
      #2;
      rst_n   = 1'b0;
      gray_in = SIZE'(g);
      #1;
      check("rst_bin_out",    int'(bin_out),    0);
      check("rst_bin_valid",  int'(bin_valid),  0);
      check("rst_bin_delta",  int'(bin_delta),  0);
      check("rst_step_err",   int'(step_err),   0);
      check("rst_sticky_err", int'(sticky_err), 0);
      check("rst_err_count",  int'(err_count),  0);
      sb.delete();
      m_prev_g = 0; m_prev_b = 0; m_cnt = 0; m_sticky = 0;
      clr_pipe0 = 1'b0; clr_pipe1 = 1'b0; clear_err = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cur_g = g;
      model_step(g, 1'b0);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n) begin
         if (bin_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               check("bin_out",    int'(bin_out),    e.bin);
               check("bin_delta",  int'(bin_delta),  e.delta);
               check("step_err",   int'(step_err),   e.err);
               check("sticky_err", int'(sticky_err), e.sticky);
               check("err_count",  int'(err_count),  e.cnt);
            end
         end else begin
            check("step_err_idle", int'(step_err), 0);
         end
      end
   end

   initial begin
      int held_bin;
      int nxt;

      // Power-on reset, then mid-stream reset with values still in the synchroniser.
      do_reset(0);
      repeat (4) step(0, 1'b0);
      step(1, 1'b0);
      step(3, 1'b0);
      do_reset(6);
      repeat (6) step(6, 1'b0);

      // Full Gray count sweep including the 15 -> 0 wrap.
      do_reset(0);
      repeat (4) step(0, 1'b0);
      for (int n = 1; n <= MAXV; n++) begin
         repeat (4) step(gray_of(n % MAXV), 1'b0);
      end

      // Back-to-back single-cycle updates.
      step(1, 1'b0);
      step(3, 1'b0);
      step(2, 1'b0);
      repeat (4) step(2, 1'b0);

      // Illegal step 0001 -> 0111, then saturation and clear-coincident error.
      do_reset(0);
      repeat (4) step(1, 1'b0);
      repeat (4) step(7, 1'b0);
      for (int k = 0; k < 5; k++) begin
         nxt = (cur_g == 7) ? 1 : 7;
         repeat (4) step(nxt, 1'b0);
      end
      nxt = (cur_g == 7) ? 1 : 7;
      step(nxt, 1'b1);
      repeat (5) step(nxt, 1'b0);

      // Static input.
      held_bin = m_prev_b;
      repeat (20) step(cur_g, 1'b0);
      check("static_bin_out", int'(bin_out), held_bin);

      // Random walk with random hold times and occasional clears.
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 2) == 0) nxt = int'($urandom_range(0, MAXV-1));
         else                           nxt = cur_g;
         step(nxt, ($urandom_range(0, 15) == 0));
      end

      repeat (8) step(cur_g, 1'b0);
      check("scoreboard_drained", sb.size(), 0);
      check("final_err_count",  int'(err_count),  m_cnt);
      check("final_sticky_err", int'(sticky_err), m_sticky);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gray_binary_rx.md
Name: gray_binary_rx

Overview:
- Receive end of the binary-to-Gray pointer path.
- Accepts a Gray-coded bus driven from another clock domain, resynchronises it into the local clock, and decodes it to binary.
- Flags illegal multi-bit steps and reports the binary increment per update.
- Sits on the read side of pointer-crossing logic, such as async FIFO occupancy tracking and counter monitors.

Parameters:
- SIZE, 4, width of the Gray/binary bus (≥2).
- SYNC_STAGES, 2, synchroniser flop depth (≥2).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  local clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- gray_in  input  SIZE  Gray-coded value from the foreign domain. Asynchronous to clk.
- clear_err  input  1  synchronous clear of err_count and sticky_err.
- bin_out  output  SIZE  registered binary decode of the synchronised Gray value.
- bin_valid  output  1  one-cycle pulse when bin_out takes a new value.
- bin_delta  output  SIZE  (new − old) mod 2^SIZE. Meaningful only while bin_valid=1.
- step_err  output  1  one-cycle pulse, coincident with bin_valid, when more than one bit changed.
- sticky_err  output  1  set by any step_err, held until clear_err.
- err_count  output  ERR_W  number of step errors, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All sync flops, the previous-Gray register and bin_out clear to 0.
  - bin_valid, step_err, bin_delta, sticky_err and err_count clear to 0.
  - Release is sampled on the next clk edge.
  - A reset asserted mid-operation discards all in-flight stages. No bin_valid is produced for the discarded values.
- Synchroniser: a plain shift chain of SYNC_STAGES flops on gray_in. No logic between stages.
- Decode stage (1 register):
  - g_s is the last sync stage; g_prev is the registered previous g_s.
  - Decode rule: b[SIZE-1] = g_s[SIZE-1]; b[i] = b[i+1] XOR g_s[i] for i = SIZE-2 down to 0 (prefix XOR from the MSB).
  - When g_s ≠ g_prev on a cycle, the next edge does all of:
    - bin_out ← b
    - bin_valid ← 1
    - bin_delta ← b − bin_out (mod 2^SIZE)
    - step_err ← (popcount(g_s XOR g_prev) > 1)
    - g_prev ← g_s
  - When g_s = g_prev: bin_valid=0, step_err=0, and bin_out and bin_delta hold.
- Latency: a change on gray_in appears on bin_out/bin_valid SYNC_STAGES+1 edges later (3 with defaults).
- A new value can be accepted every cycle. There is no backpressure and no handshake stall.
- Wrap-around: Gray 1000 (bin 15) → 0000 (bin 0) is a legal single-bit step.
  - bin_delta = 1, step_err = 0.
- Multi-bit change:
  - bin_out still updates to the decoded value; the decoded value is not held back.
  - step_err=1, sticky_err←1, err_count increments.
  - err_count saturates at 2^ERR_W−1 and does not wrap.
- clear_err together with step_err in the same cycle: clear wins.
  - err_count←0, sticky_err←0.
  - step_err and bin_valid still pulse normally.
- First update after reset is compared against g_prev=0.
  - Example: gray_in=0001 gives bin_out=0001, delta=1, no error.
- No state machine beyond the pipeline registers. Outputs are all registered; there are no combinational paths from input to output.

Decomposition:
- Shared package gray_pkg containing:
  - function gray2bin(SIZE-parameterised prefix XOR)
  - function popcount_gt1
  - constant SYNC_MIN = 2, used for parameter checking via an elaboration-time assertion.
- One sub-module: sync_chain (parameters WIDTH, STAGES; ports clk, rst_n, d, q).
  - Reusable by the matching binary_gray transmit side and by FIFO pointer crossings.
- Decode, compare and error-count logic stay in gray_binary_rx.

Test Plan:
- Reset: assert rst_n=0 mid-stream with gray_in=0110 → all outputs 0 immediately. After release, first bin_valid appears 3 edges after the last gray_in change, with bin_out=0100.
- Full count sweep: drive the Gray sequence for 0..15 then back to 0, one value every 4 cycles. Required response for every step:
  - bin_out matches the binary count
  - bin_delta=1
  - step_err=0
  - at 15→0 (1000→0000): bin_out=0000, delta=1.
- Back-to-back updates: change gray_in every cycle 0000→0001→0011→0010 → bin_valid high 3 consecutive cycles with bin_out 1, 2, 3 and delta=1 each.
- Illegal step: 0001→0111 (bin 1→5) → bin_out=0101, bin_delta=4, step_err pulse, sticky_err=1, err_count=1.
- Saturation and clear priority (ERR_W=2):
  - 5 illegal steps → err_count stops at 3.
  - Then clear_err coincident with a 6th illegal step → err_count=0, sticky_err=0, step_err pulses.
- Static input: hold gray_in constant for 20 cycles → bin_valid and step_err stay 0, bin_out stable.
